// File: rtl/sobel_pkg.sv
// sobel_pkg
// Shared definitions for the Sobel frame controller: FSM state encoding,
// default geometry and a counter-width helper.
package sobel_pkg;

  localparam int unsigned DEF_IMG_W  = 64;
  localparam int unsigned DEF_IMG_H  = 64;
  localparam int unsigned DEF_KERNEL = 3;

  // Codes 5..7 are unused and fall back to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FILL  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sobel_pix_counter.sv
// sobel_pix_counter
// Column/row raster position counter. Column advances on every increment
// and wraps at IMG_W-1, carrying into the row; the row wraps at IMG_H-1 so
// the last pixel of a frame returns the position to (0,0).
// Ports:
//   clk_i   - clock
//   rst_i   - synchronous active-high reset
//   clr_i   - synchronous clear to (0,0)
//   inc_i   - advance one pixel
//   col_o   - current column
//   row_o   - current row
module sobel_pix_counter
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W = DEF_IMG_W,
  parameter int unsigned IMG_H = DEF_IMG_H,
  parameter int unsigned COL_W = cnt_w(IMG_W),
  parameter int unsigned ROW_W = cnt_w(IMG_H)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
    end else if (inc_i) begin
      if (col_q == LAST_COL) begin
        col_d = '0;
        row_d = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o = col_q;
  assign row_o = row_q;

endmodule

// File: rtl/sobel_frame_ctrl.sv
// sobel_frame_ctrl
// Frame sequencer for a KERNELxKERNEL Sobel datapath: clears the line
// buffers, fills the first KERNEL-1 rows, runs until the last pixel of the
// frame, then pulses Finish and counts the frame.
//
// state | meaning
// IDLE  | waiting for start, datapath held in clear
// CLEAR | one cycle, line buffers and position counters cleared
// FILL  | accepting pixels before the first full window
// RUN   | accepting pixels, windows complete
// DONE  | one cycle, finish pulse, frame counted
//
// Ports:
//   clk_i, rst_i           - clock, synchronous active-high reset
//   start_i, continuous_i  - frame request / auto-restart after DONE
//   abort_i                - abandon the frame in progress
//   in_valid_i, out_ready_i- upstream pixel present / downstream ready
//   clear_o, enable_o      - datapath clear / pixel accepted (shift)
//   win_valid_o            - accepted pixel completes a full window
//   col_o, row_o           - position of the pixel currently offered
//   busy_o, finish_o       - frame in progress / frame-complete pulse
//   frame_cnt_o            - completed frames, wraps at 2^16
//   current_state_o        - FSM state code
module sobel_frame_ctrl
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W  = DEF_IMG_W,
  parameter int unsigned IMG_H  = DEF_IMG_H,
  parameter int unsigned KERNEL = DEF_KERNEL,
  localparam int unsigned COL_W = cnt_w(IMG_W),
  localparam int unsigned ROW_W = cnt_w(IMG_H)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             continuous_i,
  input  logic             abort_i,
  input  logic             in_valid_i,
  input  logic             out_ready_i,
  output logic             clear_o,
  output logic             enable_o,
  output logic             win_valid_o,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o,
  output logic             busy_o,
  output logic             finish_o,
  output logic [15:0]      frame_cnt_o,
  output logic [2:0]       current_state_o
);

  localparam logic [COL_W-1:0] WIN_COL   = COL_W'(KERNEL - 1);
  localparam logic [ROW_W-1:0] WIN_ROW   = ROW_W'(KERNEL - 1);
  localparam logic [COL_W-1:0] FILL_COL  = COL_W'(KERNEL - 2);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(IMG_H - 1);

  state_e           state_q, state_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             accept;
  logic             fill_end;
  logic             frame_end;

  // Outputs are gated by rst_i so the reset cycle itself already looks idle,
  // regardless of the state the register still holds.
  assign accept = ~rst_i & in_valid_i & out_ready_i &
                  ((state_q == ST_FILL) || (state_q == ST_RUN));

  assign fill_end  = accept && (row == WIN_ROW)  && (col == FILL_COL);
  assign frame_end = accept && (row == LAST_ROW) && (col == LAST_COL);

  sobel_pix_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_pix_counter (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (state_q == ST_CLEAR),
    .inc_i (accept),
    .col_o (col),
    .row_o (row)
  );

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ST_IDLE:  state_d = start_i ? ST_CLEAR : ST_IDLE;
      ST_CLEAR: state_d = abort_i ? ST_IDLE : ST_FILL;
      ST_FILL: begin
        if (abort_i)       state_d = ST_IDLE;
        else if (fill_end) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (abort_i)        state_d = ST_IDLE;
        else if (frame_end) state_d = ST_DONE;
      end
      ST_DONE: begin
        frame_cnt_d = frame_cnt_q + 16'd1;
        state_d     = (continuous_i || start_i) ? ST_CLEAR : ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign enable_o        = accept;
  assign win_valid_o     = accept && (row >= WIN_ROW) && (col >= WIN_COL);
  assign clear_o         = rst_i | (state_q == ST_IDLE) | (state_q == ST_CLEAR);
  assign busy_o          = ~rst_i & ((state_q == ST_CLEAR) || (state_q == ST_FILL) ||
                                     (state_q == ST_RUN));
  assign finish_o        = ~rst_i & (state_q == ST_DONE);
  assign col_o           = col;
  assign row_o           = row;
  assign frame_cnt_o     = frame_cnt_q;
  assign current_state_o = state_q;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
module tb_sobel_frame_ctrl;

  localparam int W = 4;
  localparam int H = 4;
  localparam int K = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, cont, abort, in_valid, out_ready;
  logic        clear, enable, win_valid, busy, finish;
  logic [1:0]  col, row;
  logic [15:0] fcnt;
  logic [2:0]  cstate;

  sobel_frame_ctrl #(.IMG_W(W), .IMG_H(H), .KERNEL(K)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .continuous_i    (cont),
    .abort_i         (abort),
    .in_valid_i      (in_valid),
    .out_ready_i     (out_ready),
    .clear_o         (clear),
    .enable_o        (enable),
    .win_valid_o     (win_valid),
    .col_o           (col),
    .row_o           (row),
    .busy_o          (busy),
    .finish_o        (finish),
    .frame_cnt_o     (fcnt),
    .current_state_o (cstate)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: mode code (0 idle,1 clear,2 fill,3 run,4 done),
  // linear pixel index within the frame, completed-frame count.
  int m_mode = 0;
  int m_pix  = 0;
  int m_fcnt = 0;

  // Event tallies of DUT activity, used by the directed literal checks.
  int cyc, en_cnt, win_cnt, win_sum, fin_cnt, run_at_en, last_en_cyc, fin_cyc, fin_then_clear;
  bit seen_run, prev_fin;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_mon();
    en_cnt = 0; win_cnt = 0; win_sum = 0; fin_cnt = 0; run_at_en = -1;
    last_en_cyc = 0; fin_cyc = 0; fin_then_clear = 0; seen_run = 0; prev_fin = 0;
  endtask

  always @(negedge clk) begin
    int e_col, e_row, old;
    bit e_acc;
    e_col = m_pix % W;
    e_row = (m_pix / W) % H;
    e_acc = !rst && in_valid && out_ready && (m_mode == 2 || m_mode == 3);

    chk("state",     int'(cstate),    m_mode);
    chk("clear",     int'(clear),     int'(rst || m_mode <= 1));
    chk("busy",      int'(busy),      int'(!rst && m_mode >= 1 && m_mode <= 3));
    chk("enable",    int'(enable),    int'(e_acc));
    chk("win_valid", int'(win_valid), int'(e_acc && e_row >= K-1 && e_col >= K-1));
    chk("finish",    int'(finish),    int'(!rst && m_mode == 4));
    chk("col",       int'(col),       e_col);
    chk("row",       int'(row),       e_row);
    chk("frame_cnt", int'(fcnt),      m_fcnt);

    cyc++;
    if (cstate == 3'd3 && !seen_run) begin seen_run = 1; run_at_en = en_cnt; end
    if (prev_fin && cstate == 3'd1) fin_then_clear++;
    prev_fin = finish;
    if (enable) begin en_cnt++; last_en_cyc = cyc; end
    if (win_valid) begin win_cnt++; win_sum += int'(row) * W + int'(col); end
    if (finish) begin fin_cnt++; fin_cyc = cyc; end

    if (rst) begin
      m_mode = 0; m_pix = 0; m_fcnt = 0;
    end else begin
      case (m_mode)
        0: if (start) m_mode = 1;
        1: begin m_pix = 0; m_mode = abort ? 0 : 2; end
        2, 3: begin
          old = m_pix;
          if (e_acc) m_pix = (m_pix + 1) % (W * H);
          if (abort) m_mode = 0;
          else if (m_mode == 2 && e_acc && old == (K-1)*W + K-2) m_mode = 3;
          else if (m_mode == 3 && e_acc && old == W*H - 1) m_mode = 4;
        end
        4: begin m_fcnt = (m_fcnt + 1) % 65536; m_mode = (cont || start) ? 1 : 0; end
        default: m_mode = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; start = 0; cont = 0; abort = 0;
    tick(); tick();
    rst = 0;
    clear_mon();
  endtask

  task automatic wait_fin(input int n, input int budget);
    int k = 0;
    while (fin_cnt < n && k < budget) begin tick(); k++; end
    if (fin_cnt < n) chk("finish_timeout", fin_cnt, n);
  endtask

  initial begin
    int k;
    rst = 1; start = 0; cont = 0; abort = 0; in_valid = 0; out_ready = 0;
    cyc = 0;
    clear_mon();
    repeat (3) tick();
    rst = 0;
    tick();
    chk("rst_state", int'(cstate), 0);
    chk("rst_clear", int'(clear), 1);
    chk("rst_frame_cnt", int'(fcnt), 0);

    // Single frame, no stalls.
    do_reset();
    in_valid = 1; out_ready = 1; start = 1;
    tick(); start = 0;
    wait_fin(1, 100);
    chk("f1_enables", en_cnt, 16);
    chk("f1_run_after_en", run_at_en, 10);
    chk("f1_win_cnt", win_cnt, 4);
    chk("f1_win_pos_sum", win_sum, 2*W+2 + 2*W+3 + 3*W+2 + 3*W+3);
    chk("f1_finish_cnt", fin_cnt, 1);
    chk("f1_finish_lat", fin_cyc - last_en_cyc, 1);
    chk("f1_frame_cnt", int'(fcnt), 1);

    // Backpressure: ready toggles every cycle.
    do_reset();
    in_valid = 1; out_ready = 1; start = 1;
    tick(); start = 0;
    k = 0;
    while (fin_cnt < 1 && k < 200) begin out_ready = ~out_ready; tick(); k++; end
    if (fin_cnt < 1) chk("bp_finish_timeout", fin_cnt, 1);
    out_ready = 1;
    chk("bp_enables", en_cnt, 16);
    chk("bp_win_cnt", win_cnt, 4);
    chk("bp_win_pos_sum", win_sum, 50);

    // Continuous for three frames.
    do_reset();
    in_valid = 1; out_ready = 1; cont = 1; start = 1;
    tick(); start = 0;
    wait_fin(3, 300);
    cont = 0;
    tick();
    chk("cont_finish_cnt", fin_cnt, 3);
    chk("cont_clear_after_done", fin_then_clear, 3);
    chk("cont_frame_cnt", int'(fcnt), 3);
    abort = 1; tick(); abort = 0;
    chk("cont_abort_state", int'(cstate), 0);
    chk("cont_abort_frame_cnt", int'(fcnt), 3);

    // Abort on the 7th accepted pixel, then restart.
    do_reset();
    in_valid = 1; out_ready = 1; start = 1;
    tick(); start = 0;
    k = 0;
    while (en_cnt < 6 && k < 50) begin tick(); k++; end
    abort = 1; tick(); abort = 0;
    chk("abort_state", int'(cstate), 0);
    chk("abort_enables", en_cnt, 7);
    chk("abort_col_held", int'(col), 3);
    chk("abort_row_held", int'(row), 1);
    repeat (3) tick();
    chk("abort_no_finish", fin_cnt, 0);
    chk("abort_frame_cnt", int'(fcnt), 0);
    start = 1; tick(); start = 0;
    tick();
    chk("restart_state", int'(cstate), 2);
    chk("restart_col", int'(col), 0);
    chk("restart_row", int'(row), 0);
    abort = 1; tick(); abort = 0;

    // Reset during RUN of the second frame.
    do_reset();
    in_valid = 1; out_ready = 1; cont = 1; start = 1;
    tick(); start = 0;
    wait_fin(1, 100);
    cont = 0; seen_run = 0;
    k = 0;
    while (!seen_run && k < 50) begin tick(); k++; end
    chk("rr_reached_run", int'(seen_run), 1);
    tick();
    rst = 1; tick(); rst = 0;
    chk("rr_state", int'(cstate), 0);
    chk("rr_col", int'(col), 0);
    chk("rr_row", int'(row), 0);
    chk("rr_frame_cnt", int'(fcnt), 0);
    repeat (20) tick();
    chk("rr_finish_cnt", fin_cnt, 1);

    // Start held through DONE.
    do_reset();
    in_valid = 1; out_ready = 1; start = 1;
    tick();
    wait_fin(1, 100);
    chk("hold_start_clear", int'(cstate), 1);
    start = 0;
    tick();
    chk("hold_start_fill", int'(cstate), 2);
    abort = 1; tick(); abort = 0;

    // Randomized traffic, checked cycle by cycle against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      start     = ($urandom_range(0, 7) == 0);
      cont      = ($urandom_range(0, 3) == 0);
      abort     = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 0; start = 0; cont = 0; abort = 0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
